// File: rtl/mem_pkg.sv
// Shared constants and FSM encoding for the RAM burst master.
package mem_pkg;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 8;
   localparam int LEN_W  = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_BURST = 2'd1,
      RD_BURST = 2'd2
   } state_e;

endpackage

// File: rtl/mem_burst_master_if.sv
// Host command/write/read channels plus the RAM port, bundled for the burst master.
interface mem_burst_master_if
   import mem_pkg::*;
#(
   parameter int ADDR_W = mem_pkg::ADDR_W,
   parameter int DATA_W = mem_pkg::DATA_W,
   parameter int LEN_W  = mem_pkg::LEN_W
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;
   logic              busy;
   logic              mem_rw_select;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, mem_data_out,
      output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy,
             mem_rw_select, mem_address, mem_data_in
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, mem_data_out,
      input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy,
             mem_rw_select, mem_address, mem_data_in
   );

endinterface

// File: rtl/mem_rsp_fifo.sv
// Two-entry response FIFO holding read data tagged with its last-beat flag.
module mem_rsp_fifo #(
   parameter int WIDTH = mem_pkg::DATA_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             valid,
   output logic [1:0]       occ
);

   logic [WIDTH-1:0] slot_q [2];
   logic [WIDTH-1:0] slot_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             push_ok_s, pop_ok_s;

   // Next-state for storage, pointers and occupancy; push on full only with a same-cycle pop.
   always_comb begin
      slot_d    = slot_q;
      pop_ok_s  = pop && (cnt_q != 2'd0);
      push_ok_s = push && ((cnt_q != 2'd2) || pop_ok_s);
      if (push_ok_s) begin
         slot_d[wr_ptr_q] = push_data;
         wr_ptr_d         = ~wr_ptr_q;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = ~rd_ptr_q;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      cnt_d = cnt_q + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
   end

   // FIFO state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q[0] <= {WIDTH{1'b0}};
         slot_q[1] <= {WIDTH{1'b0}};
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         cnt_q     <= 2'd0;
      end else begin
         slot_q    <= slot_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   assign pop_data = slot_q[rd_ptr_q];
   assign valid    = (cnt_q != 2'd0);
   assign occ      = cnt_q;

endmodule

// File: rtl/mem_burst_master.sv
// Burst read/write master that owns the single-port RAM and sequences one access per cycle.
module mem_burst_master
   import mem_pkg::*;
#(
   parameter int ADDR_W = mem_pkg::ADDR_W,
   parameter int DATA_W = mem_pkg::DATA_W,
   parameter int LEN_W  = mem_pkg::LEN_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mem_burst_master_if.master   bus
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              inflight_q, inflight_d;
   logic              inflight_last_q, inflight_last_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              wr_ready_q, wr_ready_d;

   logic              wr_beat_s;
   logic              last_beat_s;
   logic [ADDR_W-1:0] addr_inc_s;
   logic [LEN_W-1:0]  cnt_dec_s;
   logic              pop_s;
   logic [2:0]        pend_s;
   logic              credit_ok_s;
   logic              fifo_valid_s;
   logic [1:0]        fifo_occ_s;
   logic [DATA_W:0]   fifo_data_s;

   assign last_beat_s = (cnt_q == {LEN_W{1'b0}});
   assign addr_inc_s  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign cnt_dec_s   = last_beat_s ? {LEN_W{1'b0}} : (cnt_q - {{(LEN_W-1){1'b0}}, 1'b1});
   assign pop_s       = fifo_valid_s && bus.rd_ready;
   // A beat popped this cycle frees its slot in time for the next issue, keeping 1 beat/cycle.
   assign pend_s      = {1'b0, fifo_occ_s} + {2'b00, inflight_q};
   assign credit_ok_s = (pend_s < (3'd2 + {2'b00, pop_s}));

   // Burst sequencing: command latch, per-beat address/count update and read issue.
   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      cnt_d           = cnt_q;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      wr_beat_s       = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               addr_d  = bus.cmd_addr;
               cnt_d   = bus.cmd_len;
               state_d = bus.cmd_write ? WR_BURST : RD_BURST;
            end else begin
               state_d = IDLE;
            end
         end
         WR_BURST: begin
            if (bus.wr_valid) begin
               wr_beat_s = 1'b1;
               addr_d    = addr_inc_s;
               cnt_d     = cnt_dec_s;
               state_d   = last_beat_s ? IDLE : WR_BURST;
            end else begin
               state_d = WR_BURST;
            end
         end
         RD_BURST: begin
            if (credit_ok_s) begin
               inflight_d      = 1'b1;
               inflight_last_d = last_beat_s;
               addr_d          = addr_inc_s;
               cnt_d           = cnt_dec_s;
               state_d         = last_beat_s ? IDLE : RD_BURST;
            end else begin
               state_d = RD_BURST;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      cmd_ready_d = (state_d == IDLE);
      wr_ready_d  = (state_d == WR_BURST);
   end

   // FSM and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         addr_q          <= {ADDR_W{1'b0}};
         cnt_q           <= {LEN_W{1'b0}};
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         cmd_ready_q     <= 1'b1;
         wr_ready_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         cnt_q           <= cnt_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         cmd_ready_q     <= cmd_ready_d;
         wr_ready_q      <= wr_ready_d;
      end
   end

   mem_rsp_fifo #(
      .WIDTH (DATA_W + 1)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data ({inflight_last_q, bus.mem_data_out}),
      .pop       (pop_s),
      .pop_data  (fifo_data_s),
      .valid     (fifo_valid_s),
      .occ       (fifo_occ_s)
   );

   assign bus.cmd_ready     = cmd_ready_q;
   assign bus.wr_ready      = wr_ready_q;
   assign bus.rd_valid      = fifo_valid_s;
   assign bus.rd_data       = fifo_data_s[DATA_W-1:0];
   assign bus.rd_last       = fifo_data_s[DATA_W];
   assign bus.busy          = (state_q != IDLE) || fifo_valid_s || inflight_q;
   // Write beats go straight to the RAM so data lands on the edge that accepts the beat.
   assign bus.mem_rw_select = wr_beat_s;
   assign bus.mem_address   = addr_q;
   assign bus.mem_data_in   = wr_beat_s ? bus.wr_data : {DATA_W{1'b0}};

endmodule
